// File: rtl/ac_pkg.sv
// ac_pkg: shared encodings and BCD mm:ss helpers for the air-conditioner timer scheduler
package ac_pkg;
  typedef enum logic [1:0] {M_NORMAL = 2'd0, M_SLEEP = 2'd1, M_OFF = 2'd2} mode_t;
  typedef enum logic [1:0] {D_NONE = 2'd0, D_SLEEP = 2'd1, D_OFF = 2'd2} disp_t;
  typedef enum logic {B_IDLE = 1'b0, B_ON = 1'b1} beep_t;
  localparam logic SLOT_SLEEP = 1'b0;
  localparam logic SLOT_OFF = 1'b1;
  function automatic logic bcd_ok(input logic [15:0] v);
    return v[15:12] <= 4'd9 && v[11:8] <= 4'd9 && v[7:4] <= 4'd5 && v[3:0] <= 4'd9;
  endfunction
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = v;
    if (v == 16'h0) return 16'h0;
    if (s1 != 4'd0) return {m10, m1, s10, s1 - 4'd1};
    if (s10 != 4'd0) return {m10, m1, s10 - 4'd1, 4'd9};
    if (m1 != 4'd0) return {m10, m1 - 4'd1, 4'd5, 4'd9};
    return {m10 - 4'd1, 4'd9, 4'd5, 4'd9};
  endfunction
  function automatic int unsigned bcd_secs(input logic [15:0] v);
    return 32'(v[15:12]) * 32'd600 + 32'(v[11:8]) * 32'd60 + 32'(v[7:4]) * 32'd10 + 32'(v[3:0]);
  endfunction
endpackage

// File: rtl/bcd_mmss_down.sv
// bcd_mmss_down: one BCD mm:ss countdown slot with expiry and one-shot warning request
module bcd_mmss_down
  import ac_pkg::*;
#(
  parameter int unsigned WARN_S = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic        tick,
  input  logic [15:0] din,
  output logic [15:0] val,
  output logic        armed,
  output logic        expire,
  output logic        warn
);
  logic        warn_done;
  logic [15:0] nxt;
  assign nxt = bcd_dec(val);
  assign expire = tick && armed && nxt == 16'h0;
  assign warn = tick && armed && !warn_done && bcd_secs(nxt) <= WARN_S;
  // clear beats load beats countdown; a zero load simply leaves the slot disarmed
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      val <= 16'h0;
      armed <= 1'b0;
      warn_done <= 1'b0;
    end else if (load) begin
      val <= din;
      armed <= din != 16'h0;
      warn_done <= 1'b0;
    end else if (tick && armed) begin
      val <= nxt;
      armed <= nxt != 16'h0;
      warn_done <= warn_done | warn;
    end
  end
endmodule

// File: rtl/ac_timer_sched.sv
// ac_timer_sched: sleep/off countdown timers driving air level, warning buzzer and display
module ac_timer_sched
  import ac_pkg::*;
#(
  parameter int unsigned WARN_S = 30,
  parameter int unsigned BEEP_CYC = 100_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tick_1hz,
  input  logic        cfg_valid,
  input  logic        cfg_sel,
  input  logic [15:0] cfg_mmss,
  output logic        cfg_ready,
  output logic        cfg_err,
  input  logic        cancel,
  input  logic [2:0]  level_in,
  output logic [2:0]  air_condition,
  output logic        beep,
  output logic [15:0] disp_bcd,
  output logic [1:0]  disp_sel,
  output logic        sleep_active,
  output logic        off_active
);
  localparam int CW = BEEP_CYC > 1 ? $clog2(BEEP_CYC) : 1;
  logic          xfer, good, s_exp, o_exp, s_warn, o_warn, off_pick;
  logic [15:0]   s_val, o_val;
  logic [CW-1:0] cnt;
  mode_t         mode;
  beep_t         bstate;
  assign cfg_ready = !tick_1hz && !cancel;
  assign xfer = cfg_valid && cfg_ready;
  assign good = bcd_ok(cfg_mmss);
  assign off_pick = off_active && (!sleep_active || o_val <= s_val);
  bcd_mmss_down #(.WARN_S(WARN_S)) u_sleep (
    .clk(CLK), .rst(RST), .clr(cancel || o_exp), .load(xfer && good && cfg_sel == SLOT_SLEEP),
    .tick(tick_1hz), .din(cfg_mmss), .val(s_val), .armed(sleep_active), .expire(s_exp), .warn(s_warn)
  );
  bcd_mmss_down #(.WARN_S(WARN_S)) u_off (
    .clk(CLK), .rst(RST), .clr(cancel), .load(xfer && good && cfg_sel == SLOT_OFF),
    .tick(tick_1hz), .din(cfg_mmss), .val(o_val), .armed(off_active), .expire(o_exp), .warn(o_warn)
  );
  // operating mode: off expiry outranks sleep expiry; re-arming after OFF wakes the unit
  always_ff @(posedge CLK) begin
    if (RST || cancel) mode <= M_NORMAL;
    else if (o_exp) mode <= M_OFF;
    else if (s_exp) mode <= M_SLEEP;
    else if (xfer && good && cfg_mmss != 16'h0 && mode == M_OFF) mode <= M_NORMAL;
  end
  // rejected-request pulse, air level from mode, and display of the nearer deadline
  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_err <= 1'b0;
      air_condition <= 3'd0;
      disp_bcd <= 16'h0;
      disp_sel <= D_NONE;
    end else begin
      cfg_err <= xfer && !good;
      air_condition <= mode == M_OFF ? 3'd0 : (mode == M_SLEEP && level_in > 3'd1) ? 3'd1 : level_in;
      disp_bcd <= off_pick ? o_val : sleep_active ? s_val : 16'h0;
      disp_sel <= off_pick ? D_OFF : sleep_active ? D_SLEEP : D_NONE;
    end
  end
  // buzzer: any request starts one fixed-length low pulse; requests while sounding are absorbed
  always_ff @(posedge CLK) begin
    if (RST || cancel) begin
      bstate <= B_IDLE;
      cnt <= '0;
      beep <= 1'b1;
    end else if (bstate == B_IDLE) begin
      if (s_warn || o_warn) begin
        bstate <= B_ON;
        cnt <= CW'(BEEP_CYC - 1);
        beep <= 1'b0;
      end
    end else if (cnt == '0) begin
      bstate <= B_IDLE;
      beep <= 1'b1;
    end else cnt <= cnt - CW'(1);
  end
endmodule

// File: tb/tb_ac_timer_sched.sv
// tb_ac_timer_sched: directed scoreboard bench for the sleep/off timer scheduler
module tb_ac_timer_sched;
  localparam int S_AIR = 0, S_BEEP = 1, S_DISP = 2, S_SEL = 3, S_SA = 4, S_OA = 5, S_ERR = 6, S_RDY = 7, S_LOW = 8;
  typedef struct {
    int          sig;
    string       tag;
    logic [15:0] v;
  } exp_t;
  logic        CLK = 1'b0, RST = 1'b1, tick_1hz = 1'b0, cfg_valid = 1'b0, cfg_sel = 1'b0, cancel = 1'b0;
  logic [15:0] cfg_mmss = 16'h0;
  logic [2:0]  level_in = 3'd0;
  logic        cfg_ready, cfg_err, beep, sleep_active, off_active;
  logic [2:0]  air_condition;
  logic [15:0] disp_bcd;
  logic [1:0]  disp_sel;
  int          checks = 0, errors = 0, lowcnt = 0;
  exp_t        q[$];
  ac_timer_sched #(.WARN_S(30), .BEEP_CYC(8)) dut (
    .CLK(CLK), .RST(RST), .tick_1hz(tick_1hz), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
    .cfg_mmss(cfg_mmss), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cancel(cancel),
    .level_in(level_in), .air_condition(air_condition), .beep(beep), .disp_bcd(disp_bcd),
    .disp_sel(disp_sel), .sleep_active(sleep_active), .off_active(off_active)
  );
  always #5 CLK = ~CLK;
  function automatic logic [15:0] obs(input int s);
    case (s)
      S_AIR:  return {13'd0, air_condition};
      S_BEEP: return {15'd0, beep};
      S_DISP: return disp_bcd;
      S_SEL:  return {14'd0, disp_sel};
      S_SA:   return {15'd0, sleep_active};
      S_OA:   return {15'd0, off_active};
      S_ERR:  return {15'd0, cfg_err};
      S_RDY:  return {15'd0, cfg_ready};
      default: return 16'(lowcnt);
    endcase
  endfunction
  task automatic ex(input int sig, input string tag, input logic [15:0] v);
    exp_t e;
    e.sig = sig;
    e.tag = tag;
    e.v = v;
    q.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    logic [15:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.v) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, o, e.v);
      end
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      if (beep === 1'b0) lowcnt++;
    end
  endtask
  task automatic cfg(input logic sel, input logic [15:0] v);
    cfg_valid = 1'b1;
    cfg_sel = sel;
    cfg_mmss = v;
    step(1);
    cfg_valid = 1'b0;
  endtask
  task automatic tick_only();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      tick_only();
      step(1);
    end
  endtask
  task automatic do_cancel();
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    step(1);
  endtask
  initial begin
    step(2);
    RST = 1'b0;
    ex(S_RDY, "rst_ready", 1); ex(S_ERR, "rst_err", 0); ex(S_AIR, "rst_air", 0); ex(S_BEEP, "rst_beep", 1);
    ex(S_DISP, "rst_disp", 0); ex(S_SEL, "rst_sel", 0); ex(S_SA, "rst_sa", 0); ex(S_OA, "rst_oa", 0);
    drain();
    level_in = 3'd4;
    cfg(1'b0, 16'h0005);
    ex(S_SA, "t1_sa_on", 1); ex(S_AIR, "t1_air_normal", 4); ex(S_SEL, "t1_sel_lag", 0);
    drain();
    step(1);
    ex(S_DISP, "t1_disp", 16'h0005); ex(S_SEL, "t1_sel", 1);
    drain();
    lowcnt = 0;
    ticks(4);
    tick_only();
    ex(S_SA, "t1_sa_off", 0); ex(S_AIR, "t1_air_lag", 4);
    drain();
    step(1);
    ex(S_AIR, "t1_air_sleep", 1);
    drain();
    step(10);
    ex(S_LOW, "t1_beep_len", 8);
    drain();
    do_cancel();
    ex(S_AIR, "cancel_air", 4);
    drain();
    cfg(1'b1, 16'h0100);
    lowcnt = 0;
    ticks(29);
    ex(S_LOW, "t2_no_early_beep", 0); ex(S_DISP, "t2_disp_031", 16'h0031);
    drain();
    tick_only();
    ex(S_BEEP, "t2_beep_start", 0);
    drain();
    step(20);
    ex(S_LOW, "t2_beep_len", 8);
    drain();
    ticks(29);
    tick_only();
    ex(S_OA, "t2_oa_off", 0); ex(S_AIR, "t2_air_lag", 4);
    drain();
    step(1);
    ex(S_AIR, "t2_air_off", 0); ex(S_LOW, "t2_beep_once", 8); ex(S_BEEP, "t2_beep_idle", 1);
    drain();
    cfg(1'b0, 16'h0010);
    step(1);
    ex(S_AIR, "t2_wake_air", 4); ex(S_SA, "t2_wake_sa", 1);
    drain();
    do_cancel();
    cfg(1'b0, 16'h0003);
    cfg(1'b1, 16'h0003);
    lowcnt = 0;
    ticks(2);
    tick_only();
    step(1);
    ex(S_AIR, "t3_air_off", 0); ex(S_SA, "t3_sa", 0); ex(S_OA, "t3_oa", 0);
    drain();
    step(20);
    ex(S_LOW, "t3_merged_beep", 8); ex(S_SEL, "t3_sel_none", 0);
    drain();
    do_cancel();
    cfg(1'b0, 16'h0020);
    step(1);
    ex(S_DISP, "t4_disp_load", 16'h0020);
    drain();
    cfg(1'b0, 16'h0960);
    ex(S_ERR, "t4_err_pulse", 1); ex(S_SA, "t4_sa_kept", 1);
    drain();
    step(1);
    ex(S_ERR, "t4_err_clear", 0); ex(S_DISP, "t4_disp_kept", 16'h0020);
    drain();
    cfg(1'b1, 16'hA000);
    ex(S_ERR, "t4_err_m10", 1); ex(S_OA, "t4_oa_kept", 0);
    drain();
    tick_1hz = 1'b1;
    cfg_valid = 1'b1;
    cfg_sel = 1'b0;
    cfg_mmss = 16'h0045;
    #1;
    ex(S_RDY, "t4_ready_tick", 0);
    drain();
    step(1);
    tick_1hz = 1'b0;
    #1;
    ex(S_RDY, "t4_ready_after", 1);
    drain();
    step(1);
    cfg_valid = 1'b0;
    ex(S_DISP, "t4_disp_dec", 16'h0019);
    drain();
    step(1);
    ex(S_DISP, "t4_disp_held_cfg", 16'h0045); ex(S_ERR, "t4_no_err", 0);
    drain();
    do_cancel();
    cfg(1'b0, 16'h1000);
    tick_only();
    step(1);
    ex(S_DISP, "t5_borrow", 16'h0959); ex(S_SEL, "t5_sel_sleep", 1);
    drain();
    cfg(1'b0, 16'h0200);
    cfg(1'b1, 16'h0130);
    step(1);
    ex(S_DISP, "t5_disp_min", 16'h0130); ex(S_SEL, "t5_sel_off", 2);
    drain();
    cfg(1'b1, 16'h0200);
    step(1);
    ex(S_DISP, "t5_disp_tie", 16'h0200); ex(S_SEL, "t5_sel_tie", 2);
    drain();
    cfg(1'b0, 16'h0000);
    ex(S_SA, "t5_zero_disarm", 0); ex(S_OA, "t5_off_kept", 1);
    drain();
    do_cancel();
    cfg(1'b1, 16'h0010);
    cfg(1'b0, 16'h0001);
    tick_only();
    step(1);
    ex(S_AIR, "t6_air_sleep", 1); ex(S_BEEP, "t6_beeping", 0); ex(S_SA, "t6_sa", 0); ex(S_OA, "t6_oa", 1);
    drain();
    cancel = 1'b1;
    tick_1hz = 1'b1;
    cfg_valid = 1'b1;
    cfg_sel = 1'b0;
    cfg_mmss = 16'h0005;
    step(1);
    cancel = 1'b0;
    tick_1hz = 1'b0;
    cfg_valid = 1'b0;
    ex(S_BEEP, "t6_beep_cut", 1); ex(S_SA, "t6_cfg_ignored", 0); ex(S_OA, "t6_oa_clr", 0);
    drain();
    lowcnt = 0;
    step(1);
    ex(S_AIR, "t6_air_normal", 4);
    drain();
    step(10);
    ex(S_LOW, "t6_no_residual", 0); ex(S_SEL, "t6_sel_none", 0);
    drain();
    cfg(1'b1, 16'h0010);
    tick_only();
    ex(S_BEEP, "t7_beeping", 0);
    drain();
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    ex(S_BEEP, "t7_rst_beep", 1); ex(S_OA, "t7_rst_oa", 0); ex(S_AIR, "t7_rst_air", 0); ex(S_DISP, "t7_rst_disp", 0);
    drain();
    lowcnt = 0;
    step(10);
    ex(S_LOW, "t7_no_residual", 0); ex(S_AIR, "t7_air_normal", 4);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ac_timer_sched.md
AC_TIMER_SCHED -- requirements
Module: ac_timer_sched

Interface
REQ-001 Parameter WARN_S, default 30, warning threshold in seconds (binary, 1..59).
REQ-002 Parameter BEEP_CYC, default 100_000_000, beep length in CLK cycles (1 s at 100 MHz).
REQ-003 CLK  in  1  sole clock, all state on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 tick_1hz  in  1  one-cycle pulse per second.
REQ-006 cfg_valid  in  1  timer configuration request.
REQ-007 cfg_sel  in  1  0 = sleep slot, 1 = off slot.
REQ-008 cfg_mmss  in  16  BCD m10,m1,s10,s1 (bits 15:12..3:0).
REQ-009 cfg_ready  out  1  configuration can be accepted this cycle.
REQ-010 cfg_err  out  1  one-cycle pulse: request rejected, bad BCD.
REQ-011 cancel  in  1  clear both slots, restore normal mode.
REQ-012 level_in  in  3  user air level 0..5.
REQ-013 air_condition  out  3  applied air level.
REQ-014 beep  out  1  buzzer, active-low.
REQ-015 disp_bcd  out  16  remaining time of displayed slot, BCD mm:ss.
REQ-016 disp_sel  out  2  0 none, 1 sleep, 2 off.
REQ-017 sleep_active, off_active  out  1 each  slot armed.

Function
REQ-018 cfg_ready SHALL be 1 except in cycles where tick_1hz=1 or cancel=1; transfer occurs on cfg_valid && cfg_ready.
REQ-019 Transfer with any digit >9 or s10 >5 SHALL be rejected, cfg_err=1 next cycle, no state change.
REQ-020 Transfer of 0000 SHALL disarm the selected slot; any other valid value SHALL load the slot, arm it, clear its warn_done flag.
REQ-021 Transfer of nonzero value while mode OFF SHALL set mode NORMAL.
REQ-022 On tick_1hz each armed slot SHALL decrement by one second with BCD borrow (s1 0->9, s10 0->5, m1 0->9, m10); 00:00 never decremented.
REQ-023 Slot reaching 00:00 on a tick SHALL expire: disarm; sleep expiry sets mode SLEEP; off expiry sets mode OFF and disarms sleep slot.
REQ-024 Both slots expiring on one tick: off wins, mode OFF, both disarmed.
REQ-025 Mode map, registered one cycle after mode: NORMAL -> level_in; SLEEP -> 1 if level_in>1 else level_in; OFF -> 0.
REQ-026 Warning request SHALL raise on a tick edge where an armed slot's post-decrement value <= WARN_S seconds and its warn_done=0; warn_done then set.
REQ-027 Beep FSM B_IDLE/B_ON: B_IDLE->B_ON on any request, beep=0 for exactly BEEP_CYC cycles, then B_IDLE, beep=1.
REQ-028 Requests arriving in B_ON or simultaneously from both slots SHALL merge into the current/one beep, not queue.
REQ-029 Display: armed slot with smaller remaining; tie -> off slot; none -> disp_bcd=0000, disp_sel=0; registered, one-cycle latency.
REQ-030 cancel SHALL take priority over tick and cfg in the same cycle: both slots disarmed, mode NORMAL, beep FSM to B_IDLE, beep=1 next edge.
REQ-031 Tick and cfg never coincide (REQ-018); cfg_valid held across tick SHALL be accepted the following cycle.

Reset
REQ-032 RST SHALL set: slots disarmed at 0000, warn_done=0, mode NORMAL, beep FSM B_IDLE, beep counter 0.
REQ-033 Outputs after reset: cfg_ready=1, cfg_err=0, air_condition=0, beep=1, disp_bcd=0, disp_sel=0, sleep_active=0, off_active=0.
REQ-034 RST mid-beep or mid-countdown SHALL abort immediately with no residual pulse.

Structure
REQ-035 Shared package ac_pkg SHALL hold mode encodings (NORMAL/SLEEP/OFF), disp_sel encodings, slot index constants.
REQ-036 Sub-module bcd_mmss_down SHALL implement one slot (load, arm, decrement, zero/expire flag, <=threshold compare), instantiated twice.

Verification
REQ-037 Sleep load 00:05, level_in=4, 5 ticks -> air_condition 4 then 1 one cycle after mode; sleep_active 1->0.
REQ-038 Off load 01:00, WARN_S=30, BEEP_CYC=8 -> after 30th tick beep=0 exactly 8 cycles, once; after 60th tick air_condition=0.
REQ-039 Sleep 00:03 and off 00:03 loaded, 3 ticks -> mode OFF, air_condition=0, both actives 0, single merged beep.
REQ-040 cfg_mmss=0x0960 -> cfg_err pulse, slot unchanged; cfg_valid held during tick_1hz -> accepted next cycle.
REQ-041 Decrement 10:00 -> 09:59; display with sleep 02:00, off 01:30 -> disp_bcd=0x0130, disp_sel=2.
REQ-042 cancel mid-beep with tick and cfg_valid asserted -> beep=1 next edge, both slots disarmed, mode NORMAL, cfg ignored.
